// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Word-addressed data memory with a valid/ready request port and a
//   registered, back-pressurable response port. Writes honour per-byte
//   enables; addresses at or above DEPTH are flagged with rsp_err, write
//   nothing and read back 0.
//
//   Optional feature macro: DMEM_CLEAR_EN
//     Defined   - after reset the block sweeps 0 into every word, one word
//                 per cycle, before accepting requests.
//     Undefined - memory powers up uninitialised; requests are accepted
//                 from the first edge after reset release.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_write  in   1 = write, 0 = read
//   req_addr   in   [ADDR_W-1:0] word address
//   req_wdata  in   [DATA_W-1:0] write data
//   req_be     in   [DATA_W/8-1:0] byte enables (writes only)
//   rsp_valid  out  response present
//   rsp_ready  in   consumer accepts the response
//   rsp_rdata  out  [DATA_W-1:0] read data (0 for writes and errors)
//   rsp_err    out  address out of range
module data_memory_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

`ifdef DMEM_CLEAR_EN
    typedef enum logic [1:0] {S_CLEAR, S_OPEN, S_HOLD} state_e;
    localparam state_e S_RESET = S_CLEAR;
`else
    // S_BOOT holds req_ready low for the single cycle between reset release
    // and the first rising edge.
    typedef enum logic [1:0] {S_BOOT, S_OPEN, S_HOLD} state_e;
    localparam state_e S_RESET = S_BOOT;
`endif

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                in_range;
    logic [IDX_W-1:0]    idx;

    // Full-width compare: upper address bits can never alias into range.
    assign in_range  = ({1'b0, req_addr} < DEPTH_X);
    assign idx       = req_addr[IDX_W-1:0];

    assign rsp_valid = (state_q == S_HOLD);
    assign req_ready = (state_q == S_OPEN) || ((state_q == S_HOLD) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DMEM_CLEAR_EN
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             clr_last;

    assign clr_last = (clr_cnt_q == IDX_W'(DEPTH - 1));

    always_comb begin
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_last ? '0 : clr_cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef DMEM_CLEAR_EN
            S_CLEAR: if (clr_last) state_d = S_OPEN;
`else
            S_BOOT:  state_d = S_OPEN;
`endif
            S_OPEN:  if (accept) state_d = S_HOLD;
            // In HOLD an accept implies the pending response was taken too.
            S_HOLD:  if (rsp_ready && !accept) state_d = S_OPEN;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_err_d   = !in_range;
            rsp_rdata_d = (!req_write && in_range) ? mem_q[idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage has no reset; only the optional sweep initialises it.
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
        if (state_q == S_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else
`endif
        if (accept && req_write && in_range) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = 16;
`ifdef DMEM_CLEAR_EN
    localparam int unsigned EXP_LOW = DEPTH;
`else
    localparam int unsigned EXP_LOW = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [15:0]   req_addr = '0;
    logic [15:0]   req_wdata = '0;
    logic [1:0]    req_be = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic [15:0]   rsp_rdata;
    logic          rsp_err;

    data_memory_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [DEPTH];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        rr_force = 1'b0;
    logic        rr_val   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer side: random back-pressure unless a test forces a level.
    initial forever begin
        @(posedge clk);
        #1;
        rsp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] be, output int unsigned waited);
        exp_t e;
        int   ai;
        logic ok;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        waited    = 0;
        ok        = 1'b0;
        forever begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waited++;
            if (waited > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_accept_timeout: got ready=%b expected 1 within 300 cycles", req_ready);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            ai        = int'(a);
            e.acc_cyc = cyc + 1;
            e.err     = (ai >= int'(DEPTH));
            e.data    = '0;
            if (!e.err) begin
                if (w) begin
                    for (int b = 0; b < 2; b++)
                        if (be[b]) ref_mem[ai][8*b +: 8] = d[8*b +: 8];
                end else begin
                    e.data = ref_mem[ai];
                end
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic op(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        int unsigned wt;
        issue(w, a, d, be, wt);
    endtask

    // Monitor: compares on each response handshake, checks hold stability.
    logic        seen_cur = 1'b0;
    logic [16:0] held;
    int unsigned first_cyc;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid === 1'b1) begin
            if (!seen_cur) begin
                seen_cur  = 1'b1;
                first_cyc = cyc;
                held      = {rsp_err, rsp_rdata};
            end else begin
                chk("rsp_hold_stable", {15'b0, rsp_err, rsp_rdata}, {15'b0, held});
            end
            if (rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rdata=%0h err=%b expected no response", rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, e.data});
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    chk("rsp_latency", first_cyc, e.acc_cyc);
                end
                seen_cur = 1'b0;
            end
        end
    end

    task automatic release_and_count();
        int unsigned n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (req_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", n, EXP_LOW);
`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned wt;
        logic [15:0] ra;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", {16'b0, rsp_rdata}, 32'd0);
        chk("reset_rsp_err",   {31'b0, rsp_err},   32'd0);
        release_and_count();
        rr_force = 1'b1;
        rr_val   = 1'b1;

`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < 8; i++) op(1'b0, 16'(i * 9), 16'h0, 2'b00);
`endif
        for (int i = 0; i < int'(DEPTH); i++) op(1'b1, 16'(i), 16'($urandom), 2'b11);

        op(1'b1, 16'd15, 16'd200, 2'b11);
        op(1'b0, 16'd15, 16'h0, 2'b00);
        op(1'b1, 16'd12, 16'hABCD, 2'b11);
        op(1'b1, 16'd12, 16'h1234, 2'b01);
        op(1'b0, 16'd12, 16'h0, 2'b11);
        op(1'b1, 16'd200, 16'd7, 2'b11);
        op(1'b0, 16'd200, 16'h0, 2'b00);
        op(1'b0, 16'd72, 16'h0, 2'b00);
        op(1'b1, 16'h8005, 16'hFFFF, 2'b11);
        op(1'b0, 16'd5, 16'h0, 2'b00);
        op(1'b1, 16'd30, 16'h7777, 2'b00);
        op(1'b0, 16'd30, 16'h0, 2'b00);

        c0 = cyc;
        for (int i = 0; i < 10; i++) op(1'b0, 16'(i), 16'h0, 2'b00);
        chk("throughput_cycles", cyc - c0, 32'd10);

        @(negedge clk);
        rr_val = 1'b0;
        @(posedge clk);
        #1;
        op(1'b0, 16'd15, 16'h0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rdata", {16'b0, rsp_rdata}, 32'd200);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rr_val = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 16'd12, 16'h0, 2'b00, wt);
        chk("bp_same_cycle_accept", wt, 32'd0);

        rr_force = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
            op(1'($urandom), ra, 16'($urandom), 2'($urandom));
        end

        @(negedge clk);
        rr_force = 1'b1;
        rr_val   = 1'b1;
        repeat (3) @(negedge clk);
        rr_val = 1'b0;
        @(posedge clk);
        #1;
        op(1'b1, 16'd15, 16'h5555, 2'b11);
        @(negedge clk);
        chk("pre_reset_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midreset_req_ready", {31'b0, req_ready}, 32'd0);
        chk("midreset_rsp_rdata", {16'b0, rsp_rdata}, 32'd0);
        exp_q.delete();
        seen_cur = 1'b0;
        repeat (2) @(negedge clk);
        release_and_count();
        rr_val = 1'b1;
        op(1'b0, 16'd15, 16'h0, 2'b00);
        op(1'b0, 16'd3, 16'h0, 2'b00);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
